// File: rtl/pcileech_com_tx_arb_if.sv
// pcileech_com_tx_arb_if
// Bundle of the requester handshake, the packed COM write path and the
// statistics output. The slave modport is the arbiter's view; the master
// modport is the view of whoever drives the requesters and the COM side.
interface pcileech_com_tx_arb_if #(
  parameter int PARAM_NUM_REQ = 3
);
  logic [PARAM_NUM_REQ-1:0]    req_valid;
  logic [PARAM_NUM_REQ-1:0]    req_last;
  logic [64*PARAM_NUM_REQ-1:0] req_data;
  logic [PARAM_NUM_REQ-1:0]    req_ready;
  logic [255:0]                com_din;
  logic                        com_din_wr_en;
  logic                        com_din_ready;
  logic [31:0]                 stat_words;

  modport master (
    output req_valid, req_last, req_data, com_din_ready,
    input  req_ready, com_din, com_din_wr_en, stat_words
  );

  modport slave (
    input  req_valid, req_last, req_data, com_din_ready,
    output req_ready, com_din, com_din_wr_en, stat_words
  );
endinterface

// File: rtl/pcileech_com_tx_arb.sv
// pcileech_com_tx_arb
// Round-robin arbiter and packer for the 256-bit host-bound COM write path.
// One packet at a time is granted; its 64-bit words are packed four per
// 256-bit write, and a partial set is padded and pushed out after an idle
// timeout. Define COM_TX_ARB_STATS_EN to build the accepted-word counter on
// stat_words; without it stat_words is constant zero.
module pcileech_com_tx_arb #(
  parameter int          PARAM_NUM_REQ       = 3,
  parameter int          PARAM_FLUSH_TIMEOUT = 64,
  parameter logic [63:0] PARAM_PAD_WORD      = 64'h55556666_55556666
)(
  input logic                  clk,
  input logic                  rst,
  pcileech_com_tx_arb_if.slave bus
);

  localparam int GW = (PARAM_NUM_REQ > 1) ? $clog2(PARAM_NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;

  logic [63:0]   r_pack [4];
  logic [1:0]    r_slot;
  logic          r_pack_full;
  logic [255:0]  r_out;
  logic          r_out_full;
  logic [9:0]    r_timer;

  logic          w_stall;
  logic          w_out_free;
  logic          w_emit;
  logic          w_accept;
  logic [63:0]   w_word;
  logic          w_last;
  logic          w_valid_g;
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW:0]   w_cand;
  logic [255:0]  w_flush_set;

  // Backpressure only once both the output stage and the pack buffer are full
  // and the COM side refuses; otherwise the stages drain independently.
  assign w_stall    = r_out_full & ~bus.com_din_ready & r_pack_full;
  assign w_out_free = ~r_out_full | bus.com_din_ready;
  assign w_emit     = r_out_full & bus.com_din_ready;
  assign w_accept   = (r_state == S_GRANT) & w_valid_g & ~w_stall;

  assign bus.com_din       = r_out;
  assign bus.com_din_wr_en = w_emit;

  // Mux out the granted requester's word, last flag and valid.
  always_comb begin
    w_word    = '0;
    w_last    = 1'b0;
    w_valid_g = 1'b0;
    for (int i = 0; i < PARAM_NUM_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_word    = bus.req_data[64*i +: 64];
        w_last    = bus.req_last[i];
        w_valid_g = bus.req_valid[i];
      end
    end
  end

  // Only the granted requester sees ready, and only while not stalled.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < PARAM_NUM_REQ; i++) begin
      bus.req_ready[i] = (r_state == S_GRANT) && (r_grant == GW'(i)) && !w_stall;
    end
  end

  // Round-robin search: first valid requester after the previous winner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= PARAM_NUM_REQ; k++) begin
      w_cand = {1'b0, r_last_grant} + (GW+1)'(k);
      if (w_cand >= (GW+1)'(PARAM_NUM_REQ)) begin
        w_cand = w_cand - (GW+1)'(PARAM_NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_cand[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[GW-1:0];
      end
    end
  end

  // Flushed set: slots already written keep their words, the rest get pad.
  always_comb begin
    w_flush_set = '0;
    for (int k = 0; k < 4; k++) begin
      w_flush_set[64*k +: 64] = (2'(k) < r_slot) ? r_pack[k] : PARAM_PAD_WORD;
    end
  end

  // Arbiter FSM: the grant is held until the granted packet's last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(PARAM_NUM_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_accept && w_last) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Packing, output stage hand-off and idle-timeout flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot      <= '0;
      r_pack_full <= 1'b0;
      r_out       <= '0;
      r_out_full  <= 1'b0;
      r_timer     <= '0;
      for (int k = 0; k < 4; k++) begin
        r_pack[k] <= '0;
      end
    end else begin
      if (w_emit) begin
        r_out_full <= 1'b0;
      end
      if (r_pack_full && w_out_free) begin
        r_out       <= {r_pack[3], r_pack[2], r_pack[1], r_pack[0]};
        r_out_full  <= 1'b1;
        r_pack_full <= 1'b0;
      end
      if (w_accept) begin
        r_pack[r_slot] <= w_word;
        r_timer        <= '0;
        if (r_slot == 2'd3) begin
          r_slot <= 2'd0;
          if (w_out_free) begin
            r_out      <= {w_word, r_pack[2], r_pack[1], r_pack[0]};
            r_out_full <= 1'b1;
          end else begin
            r_pack_full <= 1'b1;
          end
        end else begin
          r_slot <= r_slot + 2'd1;
        end
      end else if (r_slot != 2'd0) begin
        if (r_timer >= 10'(PARAM_FLUSH_TIMEOUT - 1)) begin
          if (!r_out_full) begin
            r_out      <= w_flush_set;
            r_out_full <= 1'b1;
            r_slot     <= 2'd0;
            r_timer    <= '0;
          end
        end else begin
          r_timer <= r_timer + 10'd1;
        end
      end
    end
  end

`ifdef COM_TX_ARB_STATS_EN
  logic [31:0] r_stat_words;

  // Saturating count of requester words accepted since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_words <= '0;
    end else if (w_accept && (r_stat_words != 32'hFFFF_FFFF)) begin
      r_stat_words <= r_stat_words + 32'd1;
    end
  end

  assign bus.stat_words = r_stat_words;
`else
  assign bus.stat_words = 32'd0;
`endif

endmodule
